id_ex_stage: RTL and testbench

- ID/EX pipeline register feeding the execute-stage ALU.
- Captures decoded instruction fields and register-file operands each cycle.
- Detects load-use hazards and inserts bubbles.
- Drives final ALU operands a/b through EX/MEM and MEM/WB forwarding muxes.
- ALU op encoding is passed through unchanged: 0000 add … 1010 lui, 1100 beq, 1101 bne, 1110 bgt, 1111 blt.

---
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX/MEM, MEM/WB operand forwarding.
// Define ID_EX_FWD_EN to build the forwarding muxes and hazard detection; otherwise both are bypassed.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [3:0]        id_alu_op,
  input  logic              id_reg_we,
  input  logic              id_mem_re,
  input  logic              id_mem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_we,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_we,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [3:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_reg_we,
  output logic              ex_mem_re,
  output logic              ex_mem_we,
  output logic              hazard_stall
);

  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic            ex_alu_src;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            load_bubble;

`ifdef ID_EX_FWD_EN
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;

  // Load in EX whose destination is read by the instruction in ID
  assign hazard_stall = ex_valid & ex_mem_re & (ex_rd != '0) & id_valid &
                        ((id_rs1_used & (id_rs1 == ex_rd)) |
                         (id_rs2_used & (id_rs2 == ex_rd)));

  // Source indices are only needed to match forwarding destinations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
    end else if (!stall) begin
      if (load_bubble) begin
        ex_rs1 <= '0;
        ex_rs2 <= '0;
      end else begin
        ex_rs1 <= id_rs1;
        ex_rs2 <= id_rs2;
      end
    end
  end

  // Youngest producer wins; x0 is never forwarded
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (exmem_reg_we && (exmem_rd != '0) && (exmem_rd == ex_rs1))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_we && (memwb_rd != '0) && (memwb_rd == ex_rs1))
      fwd_rs1 = memwb_result;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (exmem_reg_we && (exmem_rd != '0) && (exmem_rd == ex_rs2))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_we && (memwb_rd != '0) && (memwb_rd == ex_rs2))
      fwd_rs2 = memwb_result;
  end
`else
  logic unused_fwd;

  // Software schedules NOPs around loads, so no hazard detection or bypass
  assign hazard_stall = 1'b0;
  assign fwd_rs1      = ex_rs1_data;
  assign fwd_rs2      = ex_rs2_data;
  assign unused_fwd   = ^{id_rs1, id_rs2, id_rs1_used, id_rs2_used,
                          exmem_rd, exmem_reg_we, exmem_result,
                          memwb_rd, memwb_reg_we, memwb_result};
`endif

  assign load_bubble = flush | hazard_stall | ~id_valid;

  // Stall holds everything; a bubble clears every control so no write or branch escapes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_imm      <= '0;
      ex_alu_src  <= 1'b0;
      ex_alu_op   <= 4'b0000;
      ex_reg_we   <= 1'b0;
      ex_mem_re   <= 1'b0;
      ex_mem_we   <= 1'b0;
    end else if (!stall) begin
      if (load_bubble) begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_rd       <= '0;
        ex_imm      <= '0;
        ex_alu_src  <= 1'b0;
        ex_alu_op   <= 4'b0000;
        ex_reg_we   <= 1'b0;
        ex_mem_re   <= 1'b0;
        ex_mem_we   <= 1'b0;
      end else begin
        ex_valid    <= 1'b1;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_rd       <= id_rd;
        ex_imm      <= id_imm;
        ex_alu_src  <= id_alu_src;
        ex_alu_op   <= id_alu_op;
        ex_reg_we   <= id_reg_we;
        ex_mem_re   <= id_mem_re;
        ex_mem_we   <= id_mem_we;
      end
    end
  end

  assign ex_a          = fwd_rs1;
  assign ex_b          = ex_alu_src ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bubbles, forwarding, stall/flush priority and async reset.
// Expectations follow whichever build ID_EX_FWD_EN selects.
module tb_id_ex_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, flush, id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_rs1_used, id_rs2_used, id_alu_src;
  logic [3:0]        id_alu_op;
  logic              id_reg_we, id_mem_re, id_mem_we;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic              exmem_reg_we, memwb_reg_we;
  logic [XLEN-1:0]   exmem_result, memwb_result;
  logic              ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, hazard_stall;
  logic [XLEN-1:0]   ex_a, ex_b, ex_store_data, ex_pc, ex_imm;
  logic [3:0]        ex_alu_op;
  logic [REG_AW-1:0] ex_rd;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rd(id_rd),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
    .exmem_rd(exmem_rd), .exmem_reg_we(exmem_reg_we), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_we(memwb_reg_we), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so outputs have settled
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic src, input logic [3:0] op,
                        input logic we, input logic re, input logic mwe);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    id_rs1_data = d1; id_rs2_data = d2; id_rd = rd; id_imm = imm;
    id_alu_src = src; id_alu_op = op; id_reg_we = we; id_mem_re = re; id_mem_we = mwe;
  endtask

  task automatic clear_fwd();
    exmem_rd = '0; exmem_reg_we = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_we = 1'b0; memwb_result = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    clear_fwd();
    step(); step();
    check("reset_valid", 32'(ex_valid), 32'd0);
    check("reset_a", ex_a, 32'd0);
    check("reset_hazard", 32'(hazard_stall), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Plain add capture
    set_id(32'h100, 5'd1, 5'd2, 32'h5, 32'h7, 5'd4, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("cap_valid", 32'(ex_valid), 32'd1);
    check("cap_a", ex_a, 32'h5);
    check("cap_b", ex_b, 32'h7);
    check("cap_op", 32'(ex_alu_op), 32'h0);
    check("cap_rd", 32'(ex_rd), 32'd4);
    check("cap_pc", ex_pc, 32'h100);

    // Forwarding priority on rs1 = x3
    set_id(32'h104, 5'd3, 5'd6, 32'h1111, 32'h22, 5'd7, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step();
    exmem_rd = 5'd3; exmem_reg_we = 1'b1; exmem_result = 32'hAAAA0000;
    memwb_rd = 5'd3; memwb_reg_we = 1'b1; memwb_result = 32'h1234;
    #1 check("fwd_exmem_wins", ex_a, FWD ? 32'hAAAA0000 : 32'h1111);
    exmem_reg_we = 1'b0;
    #1 check("fwd_memwb", ex_a, FWD ? 32'h1234 : 32'h1111);
    exmem_reg_we = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 check("fwd_x0_none", ex_a, 32'h1111);

    // Stall holds state while forwarding follows live inputs
    stall = 1'b1;
    set_id(32'h108, 5'd1, 5'd1, 32'h9, 32'h9, 5'd9, 32'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    step();
    check("stall_pc_hold", ex_pc, 32'h104);
    memwb_rd = 5'd3; memwb_result = 32'h5555;
    #1 check("stall_fwd_live", ex_a, FWD ? 32'h5555 : 32'h1111);
    stall = 1'b0; clear_fwd();

    // Load-use: lw x5 then add reading x5
    set_id(32'h10C, 5'd1, 5'd0, 32'h40, 32'h0, 5'd5, 32'h8, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    id_rs2_used = 1'b0;
    step();
    check("ld_mem_re", 32'(ex_mem_re), 32'd1);
    check("ld_b_imm", ex_b, 32'h8);
    set_id(32'h110, 5'd5, 5'd6, 32'h99, 32'h3, 5'd7, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    #1 check("lu_hazard", 32'(hazard_stall), FWD ? 32'd1 : 32'd0);
    step();
    check("lu_bubble_valid", 32'(ex_valid), FWD ? 32'd0 : 32'd1);
    check("lu_bubble_we", 32'(ex_reg_we), FWD ? 32'd0 : 32'd1);
    check("lu_hazard_clear", 32'(hazard_stall), 32'd0);
    step();
    check("lu_pass_valid", 32'(ex_valid), 32'd1);
    check("lu_pass_rd", 32'(ex_rd), 32'd7);

    // Flush a valid bne
    set_id(32'h114, 5'd1, 5'd2, 32'h1, 32'h2, 5'd0, 32'h10, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_op", 32'(ex_alu_op), 32'h0);
    flush = 1'b0;

    // Stall beats flush
    set_id(32'h200, 5'd1, 5'd2, 32'h1, 32'h2, 5'd9, 32'h0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1);
    step();
    check("pre_sf_op", 32'(ex_alu_op), 32'h9);
    set_id(32'h204, 5'd1, 5'd2, 32'h1, 32'h2, 5'd3, 32'h0, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0);
    stall = 1'b1; flush = 1'b1;
    step();
    check("sf_valid", 32'(ex_valid), 32'd1);
    check("sf_op", 32'(ex_alu_op), 32'h9);
    check("sf_rd", 32'(ex_rd), 32'd9);
    check("sf_pc", ex_pc, 32'h200);
    check("sf_mem_we", 32'(ex_mem_we), 32'd1);
    stall = 1'b0; flush = 1'b0;

    // Immediate select with rs2 forwarded to the store-data path
    set_id(32'h208, 5'd0, 5'd8, 32'h0, 32'h1, 5'd10, 32'h12, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
    step();
    exmem_rd = 5'd8; exmem_reg_we = 1'b1; exmem_result = 32'hDEAD;
    #1 check("imm_b", ex_b, 32'h12);
    check("imm_store", ex_store_data, FWD ? 32'hDEAD : 32'h1);
    check("imm_op", 32'(ex_alu_op), 32'hA);
    check("imm_imm", ex_imm, 32'h12);

    // Asynchronous reset between edges
    set_id(32'h20C, 5'd8, 5'd8, 32'h3, 32'h4, 5'd11, 32'h0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_rst_op", 32'(ex_alu_op), 32'h9);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_op", 32'(ex_alu_op), 32'h0);
    check("arst_a", ex_a, 32'd0);
    check("arst_b", ex_b, 32'd0);
    check("arst_store", ex_store_data, 32'd0);
    check("arst_we", 32'(ex_reg_we), 32'd0);
    @(negedge clk); rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
